// File: rtl/dcache_port_arbiter.sv
// Purpose: shares the single D$/memory request port between fetch, LSU load and LSU store, round-robin, one transaction outstanding.
// Latency: req_ready to done is 3 cycles minimum (grant, issue, response); at least one idle cycle between grants.
// Backpressure: losers see req_ready=0 and hold; mem_valid/payload held until mem_ready; watchdog aborts after TIMEOUT_CYCLES.
module dcache_port_arbiter #(
   parameter int INDEX_WIDTH    = 19,
   parameter int DATA_WIDTH     = 64,
   parameter int MASK_WIDTH     = 64,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   ifu_req_valid,
   input  logic [INDEX_WIDTH-1:0] ifu_req_index,
   output logic                   ifu_req_ready,
   input  logic                   ifu_flush,
   output logic                   ifu_done,
   output logic [DATA_WIDTH-1:0]  ifu_read_data,
   input  logic                   ld_req_valid,
   input  logic [INDEX_WIDTH-1:0] ld_req_index,
   output logic                   ld_req_ready,
   output logic                   ld_done,
   output logic [DATA_WIDTH-1:0]  ld_read_data,
   input  logic                   st_req_valid,
   input  logic [INDEX_WIDTH-1:0] st_req_index,
   input  logic [DATA_WIDTH-1:0]  st_write_data,
   input  logic [MASK_WIDTH-1:0]  st_write_mask,
   output logic                   st_req_ready,
   output logic                   st_done,
   output logic                   mem_valid,
   output logic [INDEX_WIDTH-1:0] mem_index,
   output logic                   mem_write,
   output logic [DATA_WIDTH-1:0]  mem_write_data,
   output logic [MASK_WIDTH-1:0]  mem_write_mask,
   input  logic                   mem_ready,
   input  logic                   mem_done,
   input  logic [DATA_WIDTH-1:0]  mem_read_data,
   output logic                   timeout_err
);

   localparam int CW = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;
   typedef enum logic [1:0] {R_IFU = 2'd0, R_LD = 2'd1, R_ST = 2'd2} req_e;

   state_e                 state_q, state_d;
   req_e                   rr_q, rr_d, owner_q, owner_d, gnt_id;
   logic                   gnt_vld;
   logic                   write_q, write_d;
   logic [INDEX_WIDTH-1:0] index_q, index_d;
   logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
   logic [MASK_WIDTH-1:0]  wmask_q, wmask_d;
   logic [DATA_WIDTH-1:0]  resp_q, resp_d;
   logic [DATA_WIDTH-1:0]  ifu_rd_q, ifu_rd_d, ld_rd_q, ld_rd_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   squash_q, squash_d, squash_now;
   logic                   expire, done_any;
   logic [DATA_WIDTH-1:0]  done_dat;

   // Round-robin pick: first valid requester starting at the pointer.
   always_comb begin
      gnt_vld = 1'b1;
      gnt_id  = R_IFU;
      case (rr_q)
         R_LD: begin
            if (ld_req_valid)       gnt_id = R_LD;
            else if (st_req_valid)  gnt_id = R_ST;
            else if (ifu_req_valid) gnt_id = R_IFU;
            else                    gnt_vld = 1'b0;
         end
         R_ST: begin
            if (st_req_valid)       gnt_id = R_ST;
            else if (ifu_req_valid) gnt_id = R_IFU;
            else if (ld_req_valid)  gnt_id = R_LD;
            else                    gnt_vld = 1'b0;
         end
         default: begin
            if (ifu_req_valid)      gnt_id = R_IFU;
            else if (ld_req_valid)  gnt_id = R_LD;
            else if (st_req_valid)  gnt_id = R_ST;
            else                    gnt_vld = 1'b0;
         end
      endcase
   end

   // FSM next state, payload capture, watchdog and flush squash.
   always_comb begin
      state_d    = state_q;
      rr_d       = rr_q;
      owner_d    = owner_q;
      write_d    = write_q;
      index_d    = index_q;
      wdata_d    = wdata_q;
      wmask_d    = wmask_q;
      resp_d     = resp_q;
      cnt_d      = cnt_q;
      expire     = 1'b0;
      squash_now = squash_q | (ifu_flush && owner_q == R_IFU);
      case (state_q)
         S_IDLE: begin
            squash_now = 1'b0;
            if (gnt_vld) begin
               state_d = S_ISSUE;
               owner_d = gnt_id;
               cnt_d   = '0;
               write_d = (gnt_id == R_ST);
               wdata_d = (gnt_id == R_ST) ? st_write_data : '0;
               wmask_d = (gnt_id == R_ST) ? st_write_mask : '0;
               case (gnt_id)
                  R_LD:    begin index_d = ld_req_index;  rr_d = R_ST;  end
                  R_ST:    begin index_d = st_req_index;  rr_d = R_IFU; end
                  default: begin index_d = ifu_req_index; rr_d = R_LD;  end
               endcase
            end
         end
         S_ISSUE: begin
            cnt_d = cnt_q + CW'(1);
            if (mem_ready && mem_done) begin
               resp_d  = mem_read_data;
               state_d = S_RESP;
            end else if (cnt_q == LIMIT) begin
               expire  = 1'b1;
               state_d = S_IDLE;
            end else if (mem_ready) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q + CW'(1);
            if (mem_done) begin
               resp_d  = mem_read_data;
               state_d = S_RESP;
            end else if (cnt_q == LIMIT) begin
               expire  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      squash_d = squash_now;
   end

   // Grant and done pulses are masked while reset is asserted so nothing is handed out and then discarded.
   assign ifu_req_ready  = !reset && state_q == S_IDLE && gnt_vld && gnt_id == R_IFU;
   assign ld_req_ready   = !reset && state_q == S_IDLE && gnt_vld && gnt_id == R_LD;
   assign st_req_ready   = !reset && state_q == S_IDLE && gnt_vld && gnt_id == R_ST;
   assign done_any       = !reset && (state_q == S_RESP || expire);
   assign done_dat       = expire ? '0 : resp_q;
   assign ifu_done       = done_any && owner_q == R_IFU && !squash_now;
   assign ld_done        = done_any && owner_q == R_LD;
   assign st_done        = done_any && owner_q == R_ST;
   assign ifu_read_data  = ifu_done ? done_dat : ifu_rd_q;
   assign ld_read_data   = ld_done ? done_dat : ld_rd_q;
   assign ifu_rd_d       = ifu_read_data;
   assign ld_rd_d        = ld_read_data;
   assign timeout_err    = !reset && expire;
   assign mem_valid      = state_q == S_ISSUE && !expire;
   assign mem_index      = index_q;
   assign mem_write      = write_q;
   assign mem_write_data = wdata_q;
   assign mem_write_mask = wmask_q;

   // State registers with synchronous reset; reset abandons any transaction silently.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= S_IDLE;
         rr_q     <= R_IFU;
         owner_q  <= R_IFU;
         write_q  <= 1'b0;
         index_q  <= '0;
         wdata_q  <= '0;
         wmask_q  <= '0;
         resp_q   <= '0;
         cnt_q    <= '0;
         squash_q <= 1'b0;
         ifu_rd_q <= '0;
         ld_rd_q  <= '0;
      end else begin
         state_q  <= state_d;
         rr_q     <= rr_d;
         owner_q  <= owner_d;
         write_q  <= write_d;
         index_q  <= index_d;
         wdata_q  <= wdata_d;
         wmask_q  <= wmask_d;
         resp_q   <= resp_d;
         cnt_q    <= cnt_d;
         squash_q <= squash_d;
         ifu_rd_q <= ifu_rd_d;
         ld_rd_q  <= ld_rd_d;
      end
   end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Purpose: directed self-checking bench for dcache_port_arbiter (watchdog shortened to 8 cycles).
// Latency: inputs driven 2 time units after each rising edge, outputs sampled 1 unit later.
// Backpressure: memory ready/done driven by hand per step.
module tb_dcache_port_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic        ifu_req_valid, ifu_flush, ifu_req_ready, ifu_done;
   logic [18:0] ifu_req_index;
   logic [63:0] ifu_read_data;
   logic        ld_req_valid, ld_req_ready, ld_done;
   logic [18:0] ld_req_index;
   logic [63:0] ld_read_data;
   logic        st_req_valid, st_req_ready, st_done;
   logic [18:0] st_req_index;
   logic [63:0] st_write_data, st_write_mask;
   logic        mem_valid, mem_write, mem_ready, mem_done, timeout_err;
   logic [18:0] mem_index;
   logic [63:0] mem_write_data, mem_write_mask, mem_read_data;

   int n_cmp = 0;
   int n_bad = 0;
   logic [2:0] ord [5];

   dcache_port_arbiter #(.INDEX_WIDTH(19), .DATA_WIDTH(64), .MASK_WIDTH(64), .TIMEOUT_CYCLES(8)) dut (
      .clock(clock), .reset(reset),
      .ifu_req_valid(ifu_req_valid), .ifu_req_index(ifu_req_index), .ifu_req_ready(ifu_req_ready),
      .ifu_flush(ifu_flush), .ifu_done(ifu_done), .ifu_read_data(ifu_read_data),
      .ld_req_valid(ld_req_valid), .ld_req_index(ld_req_index), .ld_req_ready(ld_req_ready),
      .ld_done(ld_done), .ld_read_data(ld_read_data),
      .st_req_valid(st_req_valid), .st_req_index(st_req_index), .st_write_data(st_write_data),
      .st_write_mask(st_write_mask), .st_req_ready(st_req_ready), .st_done(st_done),
      .mem_valid(mem_valid), .mem_index(mem_index), .mem_write(mem_write),
      .mem_write_data(mem_write_data), .mem_write_mask(mem_write_mask),
      .mem_ready(mem_ready), .mem_done(mem_done), .mem_read_data(mem_read_data),
      .timeout_err(timeout_err)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      ord[0] = 3'b001; ord[1] = 3'b010; ord[2] = 3'b100; ord[3] = 3'b001; ord[4] = 3'b010;
      reset = 1'b1;
      ifu_req_valid = 0; ifu_req_index = '0; ifu_flush = 0;
      ld_req_valid = 0;  ld_req_index = '0;
      st_req_valid = 0;  st_req_index = '0; st_write_data = '0; st_write_mask = '0;
      mem_ready = 0; mem_done = 0; mem_read_data = '0;
      tick(); tick();

      // reset state
      #1;
      chk("rst_mem_valid", mem_valid, 0);
      chk("rst_done", {ifu_done, ld_done, st_done}, 0);
      chk("rst_timeout", timeout_err, 0);
      chk("rst_ld_data", ld_read_data, 0);
      chk("rst_mem_write", mem_write, 0);
      tick();

      // single load, minimum latency
      reset = 0; ld_req_valid = 1; ld_req_index = 19'h1A2B3; mem_ready = 1;
      #1;
      chk("t1_ready", {st_req_ready, ld_req_ready, ifu_req_ready}, 3'b010);
      tick();
      ld_req_valid = 0;
      #1;
      chk("t1_mem_valid", mem_valid, 1);
      chk("t1_mem_index", mem_index, 19'h1A2B3);
      chk("t1_mem_write", mem_write, 0);
      chk("t1_wdata", mem_write_data, 0);
      chk("t1_wmask", mem_write_mask, 0);
      tick();
      mem_ready = 0; mem_done = 1; mem_read_data = 64'hDEADBEEF_00000001;
      #1;
      chk("t1_wait_valid", mem_valid, 0);
      chk("t1_wait_done", ld_done, 0);
      tick();
      mem_done = 0; mem_read_data = '0;
      #1;
      chk("t1_done", {ifu_done, ld_done, st_done}, 3'b010);
      chk("t1_data", ld_read_data, 64'hDEADBEEF_00000001);
      tick();
      #1;
      chk("t1_done_clr", ld_done, 0);
      chk("t1_data_hold", ld_read_data, 64'hDEADBEEF_00000001);
      tick();

      // round-robin with all requesters valid from reset
      reset = 1; ifu_req_valid = 1; ld_req_valid = 1; st_req_valid = 1;
      ifu_req_index = 19'h11; ld_req_index = 19'h22; st_req_index = 19'h33;
      #1;
      chk("rr_rst_ready", {st_req_ready, ld_req_ready, ifu_req_ready}, 0);
      tick();
      reset = 0; mem_ready = 1; mem_done = 1; mem_read_data = 64'h5555_0000_0000_0055;
      #1;
      chk("rr_rst_cleared_data", ld_read_data, 0);
      for (int c = 0; c < 15; c++) begin
         if (c > 0) #1;
         chk("rr_ready", {st_req_ready, ld_req_ready, ifu_req_ready}, (c % 3 == 0) ? ord[c / 3] : 3'b000);
         chk("rr_done", {st_done, ld_done, ifu_done}, (c % 3 == 2) ? ord[c / 3] : 3'b000);
         tick();
      end
      ifu_req_valid = 0; ld_req_valid = 0; st_req_valid = 0;

      // store held off by mem_ready for 5 cycles
      mem_ready = 0; mem_done = 0;
      st_req_valid = 1; st_req_index = 19'h00040;
      st_write_data = 64'h1122334455667788; st_write_mask = 64'h00000000FFFFFFFF;
      #1;
      chk("st_ready", {st_req_ready, ld_req_ready, ifu_req_ready}, 3'b100);
      tick();
      st_req_valid = 0; st_write_data = 64'hBAD0BAD0BAD0BAD0; st_write_mask = '1;
      for (int i = 0; i < 6; i++) begin
         mem_ready = (i == 5);
         #1;
         chk("st_mem_valid", mem_valid, 1);
         chk("st_mem_index", mem_index, 19'h00040);
         chk("st_mem_write", mem_write, 1);
         chk("st_wdata", mem_write_data, 64'h1122334455667788);
         chk("st_wmask", mem_write_mask, 64'h00000000FFFFFFFF);
         tick();
      end
      mem_ready = 0; mem_done = 1;
      #1;
      chk("st_wait_done", st_done, 0);
      tick();
      mem_done = 0;
      #1;
      chk("st_done", {st_done, ld_done, ifu_done}, 3'b100);
      chk("st_resp_valid", mem_valid, 0);
      tick();
      #1;
      chk("st_done_clr", st_done, 0);
      tick();

      // fetch flushed while waiting
      ifu_req_valid = 1; ifu_req_index = 19'h7;
      #1;
      chk("fl_ready", ifu_req_ready, 1);
      tick();
      ifu_req_valid = 0; mem_ready = 1;
      #1;
      chk("fl_issue", mem_valid, 1);
      tick();
      mem_ready = 0; ifu_flush = 1;
      #1;
      chk("fl_w0_done", ifu_done, 0);
      tick();
      ifu_flush = 0; ld_req_valid = 1; ld_req_index = 19'h55;
      for (int w = 1; w < 4; w++) begin
         #1;
         chk("fl_wait_ld_ready", ld_req_ready, 0);
         tick();
      end
      mem_done = 1; mem_read_data = 64'h0000_0000_0000_ABCD;
      #1;
      chk("fl_w4_done", ifu_done, 0);
      tick();
      mem_done = 0; mem_read_data = 64'h1234;
      #1;
      chk("fl_resp_done", ifu_done, 0);
      chk("fl_resp_data", ifu_read_data, 64'h5555_0000_0000_0055);
      chk("fl_resp_ld_ready", ld_req_ready, 0);
      tick();
      #1;
      chk("fl_ld_grant", {st_req_ready, ld_req_ready, ifu_req_ready}, 3'b010);
      chk("fl_idle_done", ifu_done, 0);
      tick();
      ld_req_valid = 0; mem_ready = 1; mem_done = 1;
      #1;
      tick();
      mem_ready = 0; mem_done = 0;
      #1;
      chk("fl_ld_done", ld_done, 1);
      chk("fl_ld_data", ld_read_data, 64'h1234);
      tick();

      // watchdog: load accepted, never completed
      ld_req_valid = 1; ld_req_index = 19'h66;
      #1;
      chk("to_ready", ld_req_ready, 1);
      tick();
      ld_req_valid = 0; mem_ready = 1;
      #1;
      chk("to_issue", mem_valid, 1);
      chk("to_issue_err", timeout_err, 0);
      tick();
      mem_ready = 0;
      for (int c = 2; c < 8; c++) begin
         #1;
         chk("to_wait_err", timeout_err, 0);
         chk("to_wait_done", ld_done, 0);
         tick();
      end
      mem_read_data = 64'hFFFF;
      #1;
      chk("to_err", timeout_err, 1);
      chk("to_done", ld_done, 1);
      chk("to_data", ld_read_data, 0);
      chk("to_mem_valid", mem_valid, 0);
      tick();
      mem_done = 1; ifu_req_valid = 1; ifu_req_index = 19'h3;
      #1;
      chk("to_err_clr", timeout_err, 0);
      chk("to_late_done", ld_done, 0);
      chk("to_data_hold", ld_read_data, 0);
      chk("to_idle_grant", ifu_req_ready, 1);
      tick();
      ifu_req_valid = 0; mem_ready = 1; mem_done = 1; mem_read_data = 64'h77;
      #1;
      tick();
      mem_ready = 0; mem_done = 0;
      #1;
      chk("to_ifu_done", ifu_done, 1);
      chk("to_ifu_data", ifu_read_data, 64'h77);
      tick();

      // reset during store wait
      st_req_valid = 1; st_req_index = 19'h123; st_write_data = 64'h1; st_write_mask = 64'h1;
      #1;
      chk("rs_st_ready", st_req_ready, 1);
      tick();
      st_req_valid = 0; mem_ready = 1;
      #1;
      chk("rs_issue_write", mem_write, 1);
      tick();
      mem_ready = 0; reset = 1;
      #1;
      chk("rs_wait_done", st_done, 0);
      tick();
      reset = 0; mem_done = 1;
      ifu_req_valid = 1; ld_req_valid = 1; st_req_valid = 1; ifu_req_index = 19'h2222;
      #1;
      chk("rs_mem_valid", mem_valid, 0);
      chk("rs_late_done", st_done, 0);
      chk("rs_rr_ifu", {st_req_ready, ld_req_ready, ifu_req_ready}, 3'b001);
      tick();
      ifu_req_valid = 0; ld_req_valid = 0; st_req_valid = 0;
      mem_ready = 1; mem_done = 1; mem_read_data = 64'h99;
      #1;
      chk("rs_ifu_index", mem_index, 19'h2222);
      chk("rs_ifu_write", mem_write, 0);
      chk("rs_st_quiet", st_done, 0);
      tick();
      mem_ready = 0; mem_done = 0;
      #1;
      chk("rs_ifu_done", {st_done, ld_done, ifu_done}, 3'b001);
      chk("rs_ifu_data", ifu_read_data, 64'h99);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dcache_port_arbiter.md
Name: dcache_port_arbiter

Overview:
- Shares the single L1 D$/memory request port between three requesters: instruction fetch (read), LSU load (read) and LSU store (write).
- Sits between the frontend fetch unit / backend mem stage and the cache/memory index channel.
- Grants requesters round-robin and keeps exactly one transaction outstanding.
- Routes the completion pulse and read data back to the owning requester; a watchdog aborts hung transactions.

Parameters:
INDEX_WIDTH, 19, width of cache line index
DATA_WIDTH, 64, read/write data width
MASK_WIDTH, 64, bit-granular write mask width
TIMEOUT_CYCLES, 1024, cycles in ISSUE+WAIT before abort; minimum 2

Ports:
clock  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
ifu_req_valid  input  1  fetch read request
ifu_req_index  input  INDEX_WIDTH  fetch index
ifu_req_ready  output  1  fetch request accepted (1-cycle pulse)
ifu_flush  input  1  cancel response of an in-flight fetch
ifu_done  output  1  fetch complete (1-cycle pulse)
ifu_read_data  output  DATA_WIDTH  fetch data, valid with ifu_done
ld_req_valid, ld_req_index, ld_req_ready, ld_done, ld_read_data  as ifu_*, for LSU load (no flush)
st_req_valid  input  1  store request
st_req_index  input  INDEX_WIDTH  store index
st_write_data  input  DATA_WIDTH  store data
st_write_mask  input  MASK_WIDTH  store bit mask
st_req_ready  output  1  store accepted (pulse)
st_done  output  1  store complete (pulse)
mem_valid  output  1  request to memory
mem_index  output  INDEX_WIDTH  request index
mem_write  output  1  1 = store, 0 = read
mem_write_data  output  DATA_WIDTH  store data
mem_write_mask  output  MASK_WIDTH  store mask
mem_ready  input  1  memory accepts request
mem_done  input  1  memory completion pulse
mem_read_data  input  DATA_WIDTH  read data, valid with mem_done
timeout_err  output  1  watchdog abort (1-cycle pulse)

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset enters IDLE, clears all outputs/registers to 0, and sets the RR pointer to ifu (order ifu→ld→st→ifu).
- IDLE:
  - If any req_valid is high, grant the first valid requester starting at the RR pointer.
  - The granted requester's req_ready is driven high combinationally in that cycle. Index, write data and mask are captured; owner and mem_write are latched. The RR pointer moves to owner+1. Next state is ISSUE.
  - Ungranted requesters see req_ready=0 and must hold their valid and payload.
- ISSUE:
  - mem_valid=1 with the registered payload, stable until mem_ready.
  - On mem_ready, go to WAIT.
  - mem_ready and mem_done in the same cycle: capture data, go to RESP.
- WAIT: on mem_done, capture mem_read_data into the response register and go to RESP. mem_done in IDLE/RESP, or in ISSUE without mem_ready, is ignored.
- RESP:
  - Pulse the owner's done for one cycle; read data is driven from the response register.
  - *_read_data holds its value until the next done for that requester.
  - Next state is IDLE, so the minimum gap between grants is 1 IDLE cycle.
  - Minimum latency is 3 cycles from req_ready to done when mem_ready and mem_done are high immediately.
- Stores: mem_write=1. Reads: mem_write=0, mem_write_data=0, mem_write_mask=0. st has no read data.
- ifu_flush:
  - Sampled in ISSUE, WAIT and RESP when the owner is ifu; it sets a sticky squash bit that clears on IDLE.
  - While squashed, the transaction still completes on memory, but ifu_done is suppressed and ifu_read_data is unchanged.
  - Flush in IDLE does not cancel a new grant in that cycle.
- Watchdog:
  - The counter is cleared on entry to ISSUE and increments in ISSUE/WAIT.
  - When it reaches TIMEOUT_CYCLES-1 without completion: pulse timeout_err, pulse the owner's done (with read data 0 for reads), deassert mem_valid, and return to IDLE the next cycle.
  - A late mem_done after abort is ignored.
- Reset mid-transaction: immediate return to IDLE, no done pulse, squash and counter cleared.

Test Plan:
- ld_req_valid=1, index=0x1A2B3, mem_ready=1, mem_done=1 on first WAIT cycle with data 0xDEADBEEF_00000001 → ld_req_ready at cycle 0, mem_valid at cycle 1 with mem_write=0, ld_done at cycle 3 with that data; ifu_done/st_done stay 0.
- All three valid continuously from reset, memory ready/done at once → grant order ifu, ld, st, ifu, ld. Each req_ready is a single pulse, with no two concurrent.
- Store index 0x00040, data 0x1122334455667788, mask 0x00000000FFFFFFFF, mem_ready held low 5 cycles → mem_valid and payload stable for 6 cycles. st_done is pulsed once after mem_done; mem_write=1.
- Fetch granted, ifu_flush=1 in WAIT, mem_done 4 cycles later → no ifu_done. The next ld request is granted in the cycle after RESP.
- TIMEOUT_CYCLES=8, ld request with mem_ready=1 and mem_done never asserted → timeout_err and ld_done pulse with read data 0 at 8 cycles after ISSUE entry; FSM is back in IDLE the next cycle.
- reset asserted in WAIT of a store → next cycle: mem_valid=0, no st_done, RR pointer=ifu. A late mem_done produces no response.
